rvv_cmd_dispatch: RTL and testbench
===================================

Name: rvv_cmd_dispatch

Overview:
- Sits directly downstream of the RVV command buffer (MultiFifo of RVVCmd) and drains its head window into the vector backend.
- Holds up to ISSUE_W commands in a registered, compacted staging buffer.
- Presents the staged commands on ISSUE_W in-order issue lanes with per-lane valid/ready.
- Returns each cycle's pop count to the buffer so the buffer can retire entries.

Parameters:
- N, 4: width of the buffer head window (fifo_data_i entries); matches the frontend/buffer N.
- ISSUE_W, 2: number of backend issue lanes and staging slots; legal range 1..N.
- CMD_BUFFER_MAX_CAPACITY, 16: buffer depth; sets fifo_fill_level_i width.
- CmdT, RVVCmd: command type carried.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- fifo_data_i  in  N x CmdT  buffer head; entry 0 is oldest.
- fifo_fill_level_i  in  $clog2(CMD_BUFFER_MAX_CAPACITY+1)  valid entries in buffer.
- fifo_pop_o  out  $clog2(N+1)  entries consumed this cycle (combinational); fed to buffer ready_out.
- issue_valid_o  out  ISSUE_W  lane i holds a command (registered).
- issue_data_o  out  ISSUE_W x CmdT  lane commands (registered); lane 0 is oldest.
- issue_ready_i  in  ISSUE_W  backend accepts lane i.
- flush_i  in  1  discard staged commands.
- idle_o  out  1  staging empty and fifo_fill_level_i == 0.
- issued_count_o  out  32  total accepted commands, wraps at 2^32.

Behaviour:
- Staging state:
  - Slots 0..ISSUE_W-1 with a valid bit each, always compacted: valid slots are 0..k-1, with k = number occupied.
  - issue_valid_o = slot valids; issue_data_o = slot data.
  - Invalid slots drive data '0.
- Accept count a:
  - a = length of the leading run of lanes with issue_valid_o[i] && issue_ready_i[i].
  - A lane is accepted only if every lower lane is accepted. A ready lane after a non-accepted lane is not consumed and must present the same command next cycle.
- Availability: avail = min(fifo_fill_level_i, N).
- Pop count: p = min(ISSUE_W - (k - a), avail). fifo_pop_o = p (combinational, same cycle).
- Next-cycle staging:
  - Surviving slots a..k-1 shift down to 0..k-a-1.
  - fifo_data_i[0..p-1] fill slots k-a..k-a+p-1 in order.
  - Command order is preserved end to end.
- Throughput: with all lanes ready and avail >= ISSUE_W, ISSUE_W commands issue every cycle.
- Latency: a command at the buffer head appears on issue lanes one cycle after it is popped.
- Full staging with no accepts: p = 0. Empty buffer: p = 0, and existing slots still drain.
- flush_i:
  - Handshakes accepted in the flush cycle count as issued (issued_count_o includes a).
  - All staged commands are dropped; next-cycle issue_valid_o = 0.
  - fifo_pop_o = 0 in the flush cycle. The buffer is not flushed by this block.
- issued_count_o: += a each cycle, including the flush cycle; registered.
- idle_o: combinational; (k == 0) && (fifo_fill_level_i == 0).
- Reset (rst high at a clock edge):
  - Clears all valid bits, slot data and issued_count_o.
  - While rst is high, fifo_pop_o = 0.
  - Reset mid-operation drops staged commands without counting them.
  - First pop is possible in the first cycle rst is low.
- Buffer contract:
  - fifo_data_i[j] is meaningful only for j < avail.
  - fifo_pop_o <= avail always. The dispatcher never pops more than the buffer holds.

Test Plan:
- Reset then fill 5 commands (ids 0..4), all lanes ready, ISSUE_W=2 -> pops 2,2,1; lanes show {0,1},{2,3},{4,-} on consecutive cycles; issued_count_o=5; idle_o=1 at end.
- Staging holds {7,8}; ready = 2'b10 -> a=0, no pop, {7,8} held unchanged; next cycle ready=2'b01 -> 7 accepted, 8 shifts to lane 0, 1 entry popped into lane 1.
- Staging holds {7,8}, fill_level=3, ready=2'b01 -> a=1, p=1; next cycle lanes {8, head0}; issued_count_o +1.
- flush_i with staging {3,4} and ready=2'b01 -> issued_count_o +1, fifo_pop_o=0, next cycle issue_valid_o=0; following cycle refills from buffer.
- rst asserted while staging full and fill_level=6 -> fifo_pop_o=0 during reset, outputs all 0 and issued_count_o=0 next cycle.
- Random stimulus: random ready and fill levels over 10k cycles -> scoreboard shows in-order, no loss and no duplication; sum(fifo_pop_o) = issued + staged count.

Source files
------------

// File: rtl/rvv_cmd_dispatch_if.sv
// Command-buffer head window and backend issue lanes for rvv_cmd_dispatch.
// slave: the dispatcher; master: the buffer/backend side driving it.
interface rvv_cmd_dispatch_if #(
  parameter int unsigned N                       = 4,
  parameter int unsigned ISSUE_W                 = 2,
  parameter int unsigned CMD_BUFFER_MAX_CAPACITY = 16,
  parameter type         CmdT                    = logic [31:0]
);
  localparam int unsigned FW = $clog2(CMD_BUFFER_MAX_CAPACITY + 1);
  localparam int unsigned PW = $clog2(N + 1);

  CmdT                fifo_data_i [N];
  logic [FW-1:0]      fifo_fill_level_i;
  logic [PW-1:0]      fifo_pop_o;
  logic [ISSUE_W-1:0] issue_valid_o;
  CmdT                issue_data_o [ISSUE_W];
  logic [ISSUE_W-1:0] issue_ready_i;
  logic               flush_i;
  logic               idle_o;
  logic [31:0]        issued_count_o;

  modport slave (
    input  fifo_data_i, fifo_fill_level_i, issue_ready_i, flush_i,
    output fifo_pop_o, issue_valid_o, issue_data_o, idle_o, issued_count_o
  );

  modport master (
    output fifo_data_i, fifo_fill_level_i, issue_ready_i, flush_i,
    input  fifo_pop_o, issue_valid_o, issue_data_o, idle_o, issued_count_o
  );
endinterface

// File: rtl/rvv_cmd_dispatch.sv
// Drains the RVV command buffer head into a compacted staging buffer and
// presents it on in-order issue lanes; returns the pop count each cycle.
module rvv_cmd_dispatch #(
  parameter int unsigned N                       = 4,
  parameter int unsigned ISSUE_W                 = 2,
  parameter int unsigned CMD_BUFFER_MAX_CAPACITY = 16,
  parameter type         CmdT                    = logic [31:0]
) (
  input  logic              clk,
  input  logic              rst,
  rvv_cmd_dispatch_if.slave bus
);
  localparam int unsigned FW = $clog2(CMD_BUFFER_MAX_CAPACITY + 1);
  localparam int unsigned PW = $clog2(N + 1);

  logic [ISSUE_W-1:0] slot_valid;
  logic [ISSUE_W-1:0] next_valid;
  CmdT                slot_data [ISSUE_W];
  CmdT                next_data [ISSUE_W];
  logic [31:0]        issued_count;

  int unsigned k, a, keep, avail, p;
  logic        run;

  // Slots are compacted, so occupancy is one past the highest valid slot.
  always_comb begin
    k = 0;
    for (int unsigned i = 0; i < ISSUE_W; i++)
      if (slot_valid[i]) k = i + 1;
    a   = 0;
    run = 1'b1;
    for (int unsigned i = 0; i < ISSUE_W; i++) begin
      run = run & slot_valid[i] & bus.issue_ready_i[i];
      if (run) a = i + 1;
    end
    keep  = k - a;
    avail = 32'(bus.fifo_fill_level_i);
    if (avail > N) avail = N;
    p = ISSUE_W - keep;
    if (p > avail) p = avail;
    if (rst || bus.flush_i) p = 0;
  end

  // Constant-index selects after unrolling: survivors shift down, pops append.
  always_comb begin
    for (int unsigned i = 0; i < ISSUE_W; i++) begin
      next_valid[i] = 1'b0;
      next_data[i]  = '0;
      if (!bus.flush_i) begin
        for (int unsigned j = 0; j < ISSUE_W; j++)
          if (j == i + a && j < k) begin
            next_valid[i] = 1'b1;
            next_data[i]  = slot_data[j];
          end
        for (int unsigned j = 0; j < N; j++)
          if (j + keep == i && j < p) begin
            next_valid[i] = 1'b1;
            next_data[i]  = bus.fifo_data_i[j];
          end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid   <= '0;
      issued_count <= '0;
      for (int unsigned i = 0; i < ISSUE_W; i++) slot_data[i] <= '0;
    end else begin
      slot_valid   <= next_valid;
      issued_count <= issued_count + a;
      for (int unsigned i = 0; i < ISSUE_W; i++) slot_data[i] <= next_data[i];
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < ISSUE_W; i++) bus.issue_data_o[i] = slot_data[i];
  end

  assign bus.issue_valid_o  = slot_valid;
  assign bus.fifo_pop_o     = PW'(p);
  assign bus.issued_count_o = issued_count;
  assign bus.idle_o         = (k == 0) && (bus.fifo_fill_level_i == FW'(0));
endmodule

// File: tb/tb_rvv_cmd_dispatch.sv
// Directed and scoreboarded checks for rvv_cmd_dispatch with N=4, ISSUE_W=2;
// a queue models the command buffer and retires entries by fifo_pop_o.
module tb_rvv_cmd_dispatch;
  localparam int unsigned N   = 4;
  localparam int unsigned IW  = 2;
  localparam int unsigned CAP = 16;
  localparam int unsigned FW  = $clog2(CAP + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rvv_cmd_dispatch_if #(.N(N), .ISSUE_W(IW), .CMD_BUFFER_MAX_CAPACITY(CAP)) bus ();

  rvv_cmd_dispatch #(.N(N), .ISSUE_W(IW), .CMD_BUFFER_MAX_CAPACITY(CAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] q [$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic lanes(input string tag, input logic [1:0] v, input logic [31:0] d0,
                       input logic [31:0] d1);
    check({tag, "_valid"}, 32'(bus.issue_valid_o), 32'(v));
    check({tag, "_d0"}, bus.issue_data_o[0], d0);
    check({tag, "_d1"}, bus.issue_data_o[1], d1);
  endtask

  task automatic drive_fifo();
    for (int j = 0; j < N; j++) bus.fifo_data_i[j] = (j < q.size()) ? q[j] : '0;
    bus.fifo_fill_level_i = FW'(q.size());
    #1;
  endtask

  // Buffer retires what the dispatcher popped at this edge.
  task automatic tick();
    int unsigned pc;
    pc = 32'(bus.fifo_pop_o);
    @(posedge clk);
    repeat (pc) void'(q.pop_front());
    #1;
    drive_fifo();
  endtask

  initial begin
    int unsigned next_id, exp_id, sum_pop, acc, a, k, avail, ep, npush;
    logic run;

    rst = 1'b1;
    bus.flush_i = 1'b0;
    bus.issue_ready_i = '0;
    drive_fifo();
    tick();
    tick();
    check("rst_valid", 32'(bus.issue_valid_o), 0);
    check("rst_count", bus.issued_count_o, 0);
    check("rst_idle", 32'(bus.idle_o), 1);

    for (int i = 0; i < 5; i++) q.push_back(32'(i));
    bus.issue_ready_i = 2'b11;
    drive_fifo();
    check("rst_hold_pop", 32'(bus.fifo_pop_o), 0);
    rst = 1'b0;
    #1;
    check("fill_pop0", 32'(bus.fifo_pop_o), 2);
    tick();
    lanes("fill_c1", 2'b11, 0, 1);
    check("fill_pop1", 32'(bus.fifo_pop_o), 2);
    tick();
    lanes("fill_c2", 2'b11, 2, 3);
    check("fill_pop2", 32'(bus.fifo_pop_o), 1);
    check("fill_cnt2", bus.issued_count_o, 2);
    tick();
    lanes("fill_c3", 2'b01, 4, 0);
    check("fill_pop3", 32'(bus.fifo_pop_o), 0);
    check("fill_busy", 32'(bus.idle_o), 0);
    tick();
    check("fill_empty", 32'(bus.issue_valid_o), 0);
    check("fill_cnt", bus.issued_count_o, 5);
    check("fill_idle", 32'(bus.idle_o), 1);

    bus.issue_ready_i = 2'b00;
    q.push_back(7);
    q.push_back(8);
    drive_fifo();
    check("hold_load_pop", 32'(bus.fifo_pop_o), 2);
    tick();
    lanes("hold_c0", 2'b11, 7, 8);
    q.push_back(20);
    q.push_back(21);
    q.push_back(22);
    bus.issue_ready_i = 2'b10;
    drive_fifo();
    check("hold_pop", 32'(bus.fifo_pop_o), 0);
    tick();
    lanes("hold_c1", 2'b11, 7, 8);
    check("hold_cnt", bus.issued_count_o, 5);
    bus.issue_ready_i = 2'b01;
    drive_fifo();
    check("part_pop", 32'(bus.fifo_pop_o), 1);
    tick();
    lanes("part_c1", 2'b11, 8, 20);
    check("part_cnt", bus.issued_count_o, 6);

    bus.issue_ready_i = 2'b11;
    drive_fifo();
    tick();
    lanes("drain_c1", 2'b11, 21, 22);
    check("drain_pop", 32'(bus.fifo_pop_o), 0);
    tick();
    check("drain_valid", 32'(bus.issue_valid_o), 0);
    check("drain_cnt", bus.issued_count_o, 10);

    q.push_back(3);
    q.push_back(4);
    bus.issue_ready_i = 2'b00;
    drive_fifo();
    tick();
    lanes("flush_pre", 2'b11, 3, 4);
    q.push_back(30);
    q.push_back(31);
    bus.issue_ready_i = 2'b01;
    bus.flush_i = 1'b1;
    drive_fifo();
    check("flush_pop", 32'(bus.fifo_pop_o), 0);
    tick();
    check("flush_valid", 32'(bus.issue_valid_o), 0);
    check("flush_cnt", bus.issued_count_o, 11);
    bus.flush_i = 1'b0;
    bus.issue_ready_i = 2'b00;
    drive_fifo();
    check("refill_pop", 32'(bus.fifo_pop_o), 2);
    tick();
    lanes("refill", 2'b11, 30, 31);

    for (int i = 0; i < 6; i++) q.push_back(32'(40 + i));
    bus.issue_ready_i = 2'b11;
    rst = 1'b1;
    drive_fifo();
    check("mrst_pop", 32'(bus.fifo_pop_o), 0);
    tick();
    lanes("mrst", 2'b00, 0, 0);
    check("mrst_cnt", bus.issued_count_o, 0);
    rst = 1'b0;
    drive_fifo();
    check("mrst_first_pop", 32'(bus.fifo_pop_o), 2);
    tick();
    lanes("mrst_after", 2'b11, 40, 41);

    rst = 1'b1;
    q.delete();
    drive_fifo();
    tick();
    rst = 1'b0;
    next_id = 100;
    exp_id  = 100;
    sum_pop = 0;
    acc     = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      npush = $urandom_range(0, 2);
      repeat (npush) if (q.size() < CAP) begin
        q.push_back(next_id);
        next_id++;
      end
      bus.issue_ready_i = 2'($urandom_range(0, 3));
      drive_fifo();
      run = 1'b1;
      a   = 0;
      for (int i = 0; i < IW; i++) begin
        run = run & bus.issue_valid_o[i] & bus.issue_ready_i[i];
        if (run) begin
          check("rnd_order", bus.issue_data_o[i], exp_id);
          exp_id++;
          a++;
        end
      end
      k     = 32'($countones(bus.issue_valid_o));
      avail = (q.size() < N) ? 32'(q.size()) : N;
      ep    = IW - (k - a);
      if (ep > avail) ep = avail;
      check("rnd_pop", 32'(bus.fifo_pop_o), ep);
      sum_pop += 32'(bus.fifo_pop_o);
      acc += a;
      tick();
    end
    bus.issue_ready_i = 2'b00;
    drive_fifo();
    k = 32'($countones(bus.issue_valid_o));
    check("rnd_count", bus.issued_count_o, acc);
    check("rnd_conserve", sum_pop, acc + k);
    check("rnd_compact", 32'(bus.issue_valid_o), (k == 2) ? 3 : k);
    if (k > 0) check("rnd_stage0", bus.issue_data_o[0], exp_id);
    if (k > 1) check("rnd_stage1", bus.issue_data_o[1], exp_id + 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
